// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared types and default parameter values for the multi-channel button
// synchroniser/debouncer (button_chan, button_sync_multi).
//
// Contents:
//   btn_state_t          per-channel debounce FSM state
//   DEF_*                default values for the block parameters
// -----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        PULSE     = 3'd2,
        HELD      = 3'd3,
        DEB_REL   = 3'd4
    } btn_state_t;

    localparam int unsigned DEF_N_CH            = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_REPEAT_DELAY    = 1000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 250;

endpackage

// File: rtl/button_chan.sv
// -----------------------------------------------------------------------------
// button_chan
// One push-button channel: SYNC_STAGES-deep synchroniser, press/release
// debounce FSM, one-cycle press pulse, held level and one-cycle release pulse.
// All outputs come from flops (FSM state or pulse register); there is no
// combinational path from btn_i to any output.
//
// Optional build macro: BUTTON_SYNC_REPEAT_EN
//   defined   - auto-repeat press pulses while the button stays held
//               (first after REPEAT_DELAY held cycles, then every
//               REPEAT_PERIOD cycles)
//   undefined - press_o pulses once per accepted press; REPEAT_* unused
//
// Ports:
//   Clk      in   system clock, all state on posedge
//   Rst_n    in   asynchronous active-low reset
//   btn_i    in   raw, unregistered button level (active-high)
//   press_o  out  one-cycle pulse per accepted press (plus auto-repeat)
//   held_o   out  high from accepted press until accepted release
//   rel_o    out  one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module button_chan
    import button_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic btn_i,
    output logic press_o,
    output logic held_o,
    output logic rel_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_chan: invalid parameter set");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bsync;
    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rel_q, rel_d;
    logic                   rep_bo;

    // ---- synchroniser: bit 0 is the metastability-exposed flop ----
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign bsync = sync_q[SYNC_STAGES-1];

    // ---- debounce FSM ----
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bsync) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            DEB_PRESS: begin
                if (!bsync) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PULSE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSE: begin
                if (bsync) begin
                    state_d = HELD;
                end else begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (!bsync) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
            DEB_REL: begin
                if (bsync) begin
                    // bounce during release: stay held, no new press pulse
                    state_d = HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
        end
    end

`ifdef BUTTON_SYNC_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_DELAY_C  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PERIOD_C = REP_W'(REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;
    logic             rep_pulse_q, rep_pulse_d;

    // ---- auto-repeat: counts held cycles, frozen while release is debounced ----
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_pulse_d = 1'b0;
        if (state_d == PULSE || state_q == IDLE) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else if ((state_q == PULSE || state_q == HELD) && bsync) begin
            // rep_first_q set once the initial delay has elapsed
            if (rep_cnt_q + 1'b1 == (rep_first_q ? REP_PERIOD_C : REP_DELAY_C)) begin
                rep_pulse_d = 1'b1;
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b0;
            rep_pulse_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            rep_pulse_q <= rep_pulse_d;
        end
    end

    assign rep_bo = rep_pulse_q;
`else
    assign rep_bo = 1'b0;
`endif

    // ---- registered outputs, decoded from state; invalid encodings decode to 0 ----
    assign press_o = (state_q == PULSE) || rep_bo;
    assign held_o  = (state_q == PULSE) || (state_q == HELD) || (state_q == DEB_REL);
    assign rel_o   = rel_q;

endmodule

// File: rtl/button_sync_multi.sv
// -----------------------------------------------------------------------------
// button_sync_multi
// Multi-channel push-button front end: one button_chan per input bit, all
// channels fully independent, sharing a single clock and reset.
//
// Optional build macro: BUTTON_SYNC_REPEAT_EN (auto-repeat press pulses while
// a button is held; see button_chan).
//
// Ports:
//   Clk    in   1     system clock
//   Rst_n  in   1     asynchronous active-low reset
//   Bis    in   N_CH  raw button levels, active-high, unregistered
//   Bo     out  N_CH  one-cycle press pulse per accepted press (and repeat)
//   Held   out  N_CH  high from accepted press until accepted release
//   Rel    out  N_CH  one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module button_sync_multi
    import button_pkg::*;
#(
    parameter int unsigned N_CH            = DEF_N_CH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [N_CH-1:0] Bis,
    output logic [N_CH-1:0] Bo,
    output logic [N_CH-1:0] Held,
    output logic [N_CH-1:0] Rel
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .Clk    (Clk),
            .Rst_n  (Rst_n),
            .btn_i  (Bis[i]),
            .press_o(Bo[i]),
            .held_o (Held[i]),
            .rel_o  (Rel[i])
        );
    end

endmodule

// File: tb/tb_button_sync_multi.sv
// -----------------------------------------------------------------------------
// tb_button_sync_multi
// Self-checking bench for button_sync_multi (N_CH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5).
// The reference model treats each channel as a level that flips once the
// synchronised input has disagreed with it for DEBOUNCE_CYCLES+1 consecutive
// samples; auto-repeat (when built in) counts undisturbed held samples.
// -----------------------------------------------------------------------------
module tb_button_sync_multi;

    localparam int N_CH            = 4;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int REPEAT_DELAY    = 10;
    localparam int REPEAT_PERIOD   = 5;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic [N_CH-1:0] Bis = '0;
    logic [N_CH-1:0] Bo, Held, Rel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    button_sync_multi #(
        .N_CH           (N_CH),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .Bis  (Bis),
        .Bo   (Bo),
        .Held (Held),
        .Rel  (Rel)
    );

    // ---------------- reference model ----------------
    logic [N_CH-1:0] hist[$];
    int              run_m[N_CH];
    logic            held_m[N_CH];
`ifdef BUTTON_SYNC_REPEAT_EN
    int              rep_m[N_CH];
    logic            first_m[N_CH];
`endif
    logic [N_CH-1:0] exp_bo, exp_held, exp_rel;

    task automatic model_reset();
        hist.delete();
        for (int s = 0; s < SYNC_STAGES; s++) hist.push_back('0);
        for (int c = 0; c < N_CH; c++) begin
            run_m[c]  = 0;
            held_m[c] = 1'b0;
`ifdef BUTTON_SYNC_REPEAT_EN
            rep_m[c]   = 0;
            first_m[c] = 1'b0;
`endif
        end
        exp_bo   = '0;
        exp_held = '0;
        exp_rel  = '0;
    endtask

    task automatic model_edge(input logic [N_CH-1:0] b);
        logic [N_CH-1:0] samp;
        samp = hist.pop_front();
        hist.push_back(b);
        exp_bo  = '0;
        exp_rel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (samp[c] != held_m[c]) begin
                run_m[c]++;
                if (run_m[c] == DEBOUNCE_CYCLES + 1) begin
                    held_m[c] = samp[c];
                    run_m[c]  = 0;
                    if (samp[c]) begin
                        exp_bo[c] = 1'b1;
`ifdef BUTTON_SYNC_REPEAT_EN
                        rep_m[c]   = 0;
                        first_m[c] = 1'b0;
`endif
                    end else begin
                        exp_rel[c] = 1'b1;
                    end
                end
            end else begin
`ifdef BUTTON_SYNC_REPEAT_EN
                if (held_m[c] && run_m[c] == 0) begin
                    rep_m[c]++;
                    if (rep_m[c] == (first_m[c] ? REPEAT_PERIOD : REPEAT_DELAY)) begin
                        exp_bo[c]  = 1'b1;
                        rep_m[c]   = 0;
                        first_m[c] = 1'b1;
                    end
                end
`endif
                run_m[c] = 0;
            end
            exp_held[c] = held_m[c];
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock edge: advance the model with the input present at the edge,
    // then compare all outputs 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        if (Rst_n) model_edge(Bis);
        else       model_reset();
        #1;
        check("model_bo", Bo, exp_bo);
        check("model_held", Held, exp_held);
        check("model_rel", Rel, exp_rel);
        check("bo_rel_same_cycle", Bo & Rel, '0);
    endtask

    function automatic logic clean_bo_at(int e);
`ifdef BUTTON_SYNC_REPEAT_EN
        return (e == 6) || (e >= 6 + REPEAT_DELAY && e <= 31 && (e - 6 - REPEAT_DELAY) % REPEAT_PERIOD == 0);
`else
        return (e == 6);
`endif
    endfunction

    function automatic logic repeat_bo_at(int off);
`ifdef BUTTON_SYNC_REPEAT_EN
        return (off >= REPEAT_DELAY) && ((off - REPEAT_DELAY) % REPEAT_PERIOD == 0);
`else
        return (off < 0);
`endif
    endfunction

    // ---------------- segment table ----------------
    typedef struct {
        logic [N_CH-1:0] bis;
        int              ncyc;
        logic [N_CH-1:0] bo_mask;   // channels expected to pulse bo_n times
        int              bo_n;
        logic [N_CH-1:0] rel_mask;  // channels expected to release once
        logic [N_CH-1:0] held_end;
    } seg_t;

    seg_t segs[12];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int boc[N_CH];
        int relc[N_CH];
        int seen;
        int rem[N_CH];

        segs[0]  = '{4'b0000, 10, 4'b0000, 0, 4'b0000, 4'b0000};
        segs[1]  = '{4'b1010, 12, 4'b1010, 1, 4'b0000, 4'b1010};
        segs[2]  = '{4'b0010, 12, 4'b0000, 0, 4'b1000, 4'b0010};
        segs[3]  = '{4'b0011,  3, 4'b0000, 0, 4'b0000, 4'b0010};
        segs[4]  = '{4'b0010,  1, 4'b0000, 0, 4'b0000, 4'b0010};
        segs[5]  = '{4'b0011,  3, 4'b0000, 0, 4'b0000, 4'b0010};
        segs[6]  = '{4'b0010, 12, 4'b0000, 0, 4'b0000, 4'b0010};
        segs[7]  = '{4'b0000, 12, 4'b0000, 0, 4'b0010, 4'b0000};
        segs[8]  = '{4'b0100, 20, 4'b0100, 1, 4'b0000, 4'b0100};
        segs[9]  = '{4'b0000,  2, 4'b0000, 0, 4'b0000, 4'b0100};
        segs[10] = '{4'b0100, 20, 4'b0000, 0, 4'b0000, 4'b0100};
        segs[11] = '{4'b0000, 12, 4'b0000, 0, 4'b0100, 4'b0000};
`ifdef BUTTON_SYNC_REPEAT_EN
        // long holds also produce repeat pulses inside these segments
        segs[2].bo_mask  = 4'b0010; segs[2].bo_n  = 2;
        segs[3].bo_mask  = 4'b0010; segs[3].bo_n  = 1;
        segs[6].bo_mask  = 4'b0010; segs[6].bo_n  = 3;
        segs[8].bo_n     = 2;
        segs[9].bo_mask  = 4'b0100; segs[9].bo_n  = 1;
        segs[10].bo_mask = 4'b0100; segs[10].bo_n = 3;
`endif

        // ---- power-on reset ----
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_bo", Bo, '0);
            check("reset_held", Held, '0);
        end
        Rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // ---- clean press on channel 0: exact latency ----
        Bis = 4'b0001;
        for (int e = 0; e < 40; e++) begin
            if (e == 30) Bis = 4'b0000;
            tick();
            check("clean_bo", Bo, {3'b000, clean_bo_at(e)});
            check("clean_held", Held, (e >= 6 && e < 36) ? 4'b0001 : 4'b0000);
            check("clean_rel", Rel, (e == 36) ? 4'b0001 : 4'b0000);
        end
        for (int i = 0; i < 10; i++) tick();

        // ---- async reset while all buttons held, then re-press after reset ----
        Bis = 4'b1111;
        for (int i = 0; i < 10; i++) tick();
        check("pre_reset_held", Held, 4'b1111);
        #2;
        Rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_bo", Bo, '0);
        check("async_reset_held", Held, '0);
        check("async_reset_rel", Rel, '0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("in_reset_held", Held, '0);
        end
        Rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check("repress_bo", Bo, (e == 7) ? 4'b1111 : 4'b0000);
            check("repress_held", Held, (e >= 7) ? 4'b1111 : 4'b0000);
        end
        Bis = 4'b0000;
        for (int i = 0; i < 15; i++) tick();

        // ---- table: simultaneous channels, glitches, release bounce ----
        for (int t = 0; t < 12; t++) begin
            Bis = segs[t].bis;
            for (int c = 0; c < N_CH; c++) begin
                boc[c]  = 0;
                relc[c] = 0;
            end
            for (int k = 0; k < segs[t].ncyc; k++) begin
                tick();
                for (int c = 0; c < N_CH; c++) begin
                    boc[c]  += int'(Bo[c]);
                    relc[c] += int'(Rel[c]);
                end
            end
            for (int c = 0; c < N_CH; c++) begin
                check_int($sformatf("seg%0d_bo_ch%0d", t, c), boc[c],
                          segs[t].bo_mask[c] ? segs[t].bo_n : 0);
                check_int($sformatf("seg%0d_rel_ch%0d", t, c), relc[c],
                          segs[t].rel_mask[c] ? 1 : 0);
            end
            check($sformatf("seg%0d_held_end", t), Held, segs[t].held_end);
        end

        // ---- long hold on channel 0: repeat pattern (or single pulse) ----
        Bis = 4'b0001;
        seen = 0;
        for (int w = 0; w < 20 && seen == 0; w++) begin
            tick();
            if (Bo[0]) seen = 1;
        end
        check_int("hold_first_bo_seen", seen, 1);
        for (int off = 1; off <= 40; off++) begin
            tick();
            check($sformatf("hold_bo_off%0d", off), Bo, {3'b000, repeat_bo_at(off)});
        end
        Bis = 4'b0000;
        for (int i = 0; i < 12; i++) tick();

        // ---- randomized toggling against the model, with one mid-run reset ----
        for (int c = 0; c < N_CH; c++) rem[c] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) begin
                #2;
                Rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_async_reset", Bo | Held | Rel, '0);
            end
            if (cyc == 1004) Rst_n = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                if (rem[c] == 0) begin
                    Bis[c] = ~Bis[c];
                    if ($urandom_range(0, 1) == 0) rem[c] = int'($urandom_range(1, 5));
                    else                           rem[c] = int'($urandom_range(6, 40));
                end
                rem[c]--;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
